// File: rtl/data_router_pkg.sv
// Shared command encodings and controller state type for the data router.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_router_pkg;

    // reg_array command encodings
    localparam logic [1:0] CMD_IB = 2'b00;  // load from line buffer
    localparam logic [1:0] CMD_SF = 2'b01;  // shift window one column
    localparam logic [1:0] CMD_IF = 2'b10;  // load from reuse FIFO
    localparam logic [1:0] CMD_NE = 2'b11;  // no operation / stall

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    // True for any command that moves data through the reg_array.
    function automatic logic cmd_is_active(input logic [1:0] cmd);
        return cmd != CMD_NE;
    endfunction

endpackage

// File: rtl/win_counter.sv
// Nested kx/ky/row window counters with wrap flags for the reg_array sequencer.
// Latency: counters update on the edge after step; flags are combinational on the counters.
// Backpressure: advances only when step is high; holds otherwise.
module win_counter #(
    parameter int KSIZE = 3,
    parameter int ROWW  = 8,
    parameter int KW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            step,
    input  logic [ROWW-1:0] row_max,
    output logic [KW-1:0]   kx,
    output logic [KW-1:0]   ky,
    output logic [ROWW-1:0] row,
    output logic            kx_last,
    output logic            ky_last,
    output logic            row_last
);

    assign kx_last  = (kx == KW'(KSIZE - 1));
    assign ky_last  = (ky == KW'(KSIZE - 1));
    assign row_last = (row == row_max);

    // kx is the fastest digit; its wrap carries into ky, whose wrap carries into row
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            kx  <= '0;
            ky  <= '0;
            row <= '0;
        end else if (step) begin
            if (kx_last) begin
                kx <= '0;
                if (ky_last) begin
                    ky  <= '0;
                    row <= row + ROWW'(1);
                end else begin
                    ky <= ky + KW'(1);
                end
            end else begin
                kx <= kx + KW'(1);
            end
        end
    end

endmodule

// File: rtl/reg_array_ctrl.sv
// Sequences IB/IF loads and SF shifts into one reg_array and tags each PE beat with kx/ky.
// Latency: first command one cycle after start accept, first pe_valid two cycles after.
// Backpressure: pe_ready or selected source ready low at an edge forces NE the next cycle (one-beat skid).
module reg_array_ctrl
    import data_router_pkg::*;
#(
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1,
    parameter int ROWW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROWW-1:0]          n_rows,
    output logic                     busy,
    output logic                     done,
    input  logic                     buf_rdy,
    output logic                     buf_rd,
    input  logic                     fifo_rdy,
    output logic                     fifo_rd,
    input  logic                     pe_ready,
    output logic [1:0]               reg_array_cmd,
    output logic                     pe_valid,
    output logic [$clog2(KSIZE)-1:0] pe_kx,
    output logic [$clog2(KSIZE)-1:0] pe_ky,
    output logic                     pe_last
);

    localparam int KW = $clog2(KSIZE);

    ctrl_state_t     state, state_nxt, after_issue;
    logic            accept, issue, src_if, src_rdy;
    logic [1:0]      cmd_sel;
    logic [ROWW-1:0] n_rows_q;
    logic [KW-1:0]   kx, ky;
    logic [ROWW-1:0] row;
    logic            kx_last, ky_last, row_last;

    // Command-stage tags, one cycle ahead of the PE-facing outputs
    logic [KW-1:0]   cmd_kx_q, cmd_ky_q;
    logic            cmd_last_q;

    win_counter #(
        .KSIZE (KSIZE),
        .ROWW  (ROWW),
        .KW    (KW)
    ) u_win_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .step     (issue),
        .row_max  (n_rows_q - ROWW'(1)),
        .kx       (kx),
        .ky       (ky),
        .row      (row),
        .kx_last  (kx_last),
        .ky_last  (ky_last),
        .row_last (row_last)
    );

    // Kernel rows already seen by the previous output row come back from the reuse FIFO
    assign src_if  = (row != '0) && (int'(ky) < (KSIZE - STRIDE));
    assign src_rdy = src_if ? fifo_rdy : buf_rdy;

    // Where to go once the current command has been issued
    assign after_issue = !kx_last             ? ST_SHIFT :
                         (ky_last && row_last) ? ST_DONE  : ST_LOAD;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and issue decision
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        cmd_sel   = CMD_NE;
        case (state)
            ST_IDLE: begin
                if (start && !busy) begin
                    accept    = 1'b1;
                    state_nxt = (n_rows == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (pe_ready && src_rdy) begin
                    issue     = 1'b1;
                    cmd_sel   = src_if ? CMD_IF : CMD_IB;
                    state_nxt = after_issue;
                end
            end
            ST_SHIFT: begin
                if (pe_ready) begin
                    issue     = 1'b1;
                    cmd_sel   = CMD_SF;
                    state_nxt = after_issue;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Job bookkeeping: row count capture, busy window and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            n_rows_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (accept) begin
                n_rows_q <= n_rows;
            end
            busy <= (state != ST_IDLE) || accept;
            done <= (state == ST_DONE);
        end
    end

    // Command stage: registered command, read strobes and beat tags
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_array_cmd <= CMD_NE;
            buf_rd        <= 1'b0;
            fifo_rd       <= 1'b0;
            cmd_kx_q      <= '0;
            cmd_ky_q      <= '0;
            cmd_last_q    <= 1'b0;
        end else begin
            reg_array_cmd <= issue ? cmd_sel : CMD_NE;
            buf_rd        <= issue && (cmd_sel == CMD_IB);
            fifo_rd       <= issue && (cmd_sel == CMD_IF);
            cmd_kx_q      <= issue ? kx : '0;
            cmd_ky_q      <= issue ? ky : '0;
            cmd_last_q    <= issue && kx_last && ky_last;
        end
    end

    // PE stage: the reg_array output is valid one cycle after its command
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_valid <= 1'b0;
            pe_kx    <= '0;
            pe_ky    <= '0;
            pe_last  <= 1'b0;
        end else begin
            pe_valid <= cmd_is_active(reg_array_cmd);
            pe_kx    <= cmd_kx_q;
            pe_ky    <= cmd_ky_q;
            pe_last  <= cmd_last_q;
        end
    end

endmodule

// File: tb/tb_reg_array_ctrl.sv
// Self-checking bench for reg_array_ctrl at KSIZE=3 with STRIDE=1 and STRIDE=2 instances.
// Latency: n/a.
// Backpressure: stalls driven through buf_rdy and pe_ready.
module tb_reg_array_ctrl;
    import data_router_pkg::*;

    logic       clk, rst, start;
    logic [7:0] n_rows;
    logic       buf_rdy, fifo_rdy, pe_ready;

    logic       busy_a, done_a, buf_rd_a, fifo_rd_a, pe_valid_a, pe_last_a;
    logic [1:0] cmd_a, pe_kx_a, pe_ky_a;
    logic       busy_b, done_b, buf_rd_b, fifo_rd_b, pe_valid_b, pe_last_b;
    logic [1:0] cmd_b, pe_kx_b, pe_ky_b;

    reg_array_ctrl #(.KSIZE(3), .STRIDE(1), .ROWW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .n_rows(n_rows),
        .busy(busy_a), .done(done_a),
        .buf_rdy(buf_rdy), .buf_rd(buf_rd_a),
        .fifo_rdy(fifo_rdy), .fifo_rd(fifo_rd_a),
        .pe_ready(pe_ready), .reg_array_cmd(cmd_a),
        .pe_valid(pe_valid_a), .pe_kx(pe_kx_a), .pe_ky(pe_ky_a), .pe_last(pe_last_a)
    );

    reg_array_ctrl #(.KSIZE(3), .STRIDE(2), .ROWW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .n_rows(n_rows),
        .busy(busy_b), .done(done_b),
        .buf_rdy(buf_rdy), .buf_rd(buf_rd_b),
        .fifo_rdy(fifo_rdy), .fifo_rd(fifo_rd_b),
        .pe_ready(pe_ready), .reg_array_cmd(cmd_b),
        .pe_valid(pe_valid_b), .pe_kx(pe_kx_b), .pe_ky(pe_ky_b), .pe_last(pe_last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kx;
        logic [1:0] ky;
        logic       last;
        logic       fin;
    } beat_t;

    typedef struct {
        int n;
        int beats;
        int buf_a;
        int fifo_a;
        int buf_b;
        int fifo_b;
        int lat;
    } vec_t;

    logic [1:0] exp_cmd_a [$];
    logic [1:0] exp_cmd_b [$];
    beat_t      exp_beat_a [$];
    logic [1:0] seq_a [18];
    logic [1:0] seq_b [18];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 0;
    bit  zero_job = 0;
    int  cmds_a, beats_a, buf_cnt_a, fifo_cnt_a, buf_cnt_b, fifo_cnt_b, ne_a, gap_a;
    bit  done_seen_a, done_seen_b;
    int  done_cyc_a, t0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Compare everything the DUTs present at this negedge against the scoreboard
    task automatic sample();
        beat_t b;
        if (cmd_a != CMD_NE) begin
            cmds_a++;
            if (exp_cmd_a.size() == 0) chk("extra_cmd_a", int'(cmd_a), int'(CMD_NE));
            else chk("cmd_a", int'(cmd_a), int'(exp_cmd_a.pop_front()));
        end else if (busy_a && cmds_a > 0 && exp_cmd_a.size() > 0) begin
            ne_a++;
        end
        chk("buf_rd_a", int'(buf_rd_a), int'(cmd_a == CMD_IB));
        chk("fifo_rd_a", int'(fifo_rd_a), int'(cmd_a == CMD_IF));
        buf_cnt_a  += int'(buf_rd_a);
        fifo_cnt_a += int'(fifo_rd_a);
        if (pe_valid_a) begin
            beats_a++;
            if (exp_beat_a.size() == 0) begin
                chk("extra_beat_a", 1, 0);
            end else begin
                b = exp_beat_a.pop_front();
                chk("pe_kx_a", int'(pe_kx_a), int'(b.kx));
                chk("pe_ky_a", int'(pe_ky_a), int'(b.ky));
                chk("pe_last_a", int'(pe_last_a), int'(b.last));
                chk("done_a", int'(done_a), int'(b.fin));
            end
        end else begin
            if (beats_a > 0 && exp_beat_a.size() > 0) gap_a++;
            if (done_a) chk("done_without_beat_a", int'(zero_job), 1);
        end
        if (done_a) begin
            done_seen_a = 1;
            done_cyc_a  = cyc;
        end
        if (cmd_b != CMD_NE) begin
            if (exp_cmd_b.size() == 0) chk("extra_cmd_b", int'(cmd_b), int'(CMD_NE));
            else chk("cmd_b", int'(cmd_b), int'(exp_cmd_b.pop_front()));
        end
        buf_cnt_b  += int'(buf_rd_b);
        fifo_cnt_b += int'(fifo_rd_b);
        if (done_b) done_seen_b = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en) sample();
        #1;
    endtask

    // Expected command streams for both strides and the beat tags of the STRIDE=1 instance
    task automatic push_exp(input int n, input bit lit);
        beat_t b;
        for (int r = 0; r < n; r++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++) begin
                    if (!lit) begin
                        exp_cmd_a.push_back(kx != 0 ? CMD_SF : ((r > 0 && ky < 2) ? CMD_IF : CMD_IB));
                        exp_cmd_b.push_back(kx != 0 ? CMD_SF : ((r > 0 && ky < 1) ? CMD_IF : CMD_IB));
                    end
                    b.kx   = 2'(kx);
                    b.ky   = 2'(ky);
                    b.last = (kx == 2 && ky == 2);
                    b.fin  = (kx == 2 && ky == 2 && r == n - 1);
                    exp_beat_a.push_back(b);
                end
        if (lit) begin
            for (int i = 0; i < 18; i++) begin
                exp_cmd_a.push_back(seq_a[i]);
                exp_cmd_b.push_back(seq_b[i]);
            end
        end
    endtask

    task automatic start_job(input int n, input bit lit);
        cmds_a = 0; beats_a = 0; buf_cnt_a = 0; fifo_cnt_a = 0;
        buf_cnt_b = 0; fifo_cnt_b = 0; ne_a = 0; gap_a = 0;
        done_seen_a = 0; done_seen_b = 0; done_cyc_a = -1;
        zero_job = (n == 0);
        push_exp(n, lit);
        start  = 1'b1;
        n_rows = 8'(n);
        tick();
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_job();
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (done_seen_a && done_seen_b && !busy_a && !busy_b) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("job_completes", int'(ok), 1);
        chk("cmd_queue_a_empty", exp_cmd_a.size(), 0);
        chk("cmd_queue_b_empty", exp_cmd_b.size(), 0);
        chk("beat_queue_a_empty", exp_beat_a.size(), 0);
    endtask

    vec_t vecs [4];
    int   guard;

    initial begin
        seq_a = '{CMD_IB, CMD_SF, CMD_SF, CMD_IB, CMD_SF, CMD_SF, CMD_IB, CMD_SF, CMD_SF,
                  CMD_IF, CMD_SF, CMD_SF, CMD_IF, CMD_SF, CMD_SF, CMD_IB, CMD_SF, CMD_SF};
        seq_b = '{CMD_IB, CMD_SF, CMD_SF, CMD_IB, CMD_SF, CMD_SF, CMD_IB, CMD_SF, CMD_SF,
                  CMD_IF, CMD_SF, CMD_SF, CMD_IB, CMD_SF, CMD_SF, CMD_IB, CMD_SF, CMD_SF};
        //          n  beats bufA fifoA bufB fifoB lat
        vecs[0] = '{2, 18,   4,   2,    5,   1,    19};
        vecs[1] = '{1, 9,    3,   0,    3,   0,    10};
        vecs[2] = '{3, 27,   5,   4,    7,   2,    28};
        vecs[3] = '{0, 0,    0,   0,    0,   0,    1};

        rst = 1'b1; start = 1'b0; n_rows = '0;
        buf_rdy = 1'b1; fifo_rdy = 1'b1; pe_ready = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_cmd", int'(cmd_a), int'(CMD_NE));
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_buf_rd", int'(buf_rd_a), 0);
        chk("rst_fifo_rd", int'(fifo_rd_a), 0);
        chk("rst_pe_valid", int'(pe_valid_a), 0);
        chk("rst_pe_kx", int'(pe_kx_a), 0);
        chk("rst_pe_ky", int'(pe_ky_a), 0);
        chk("rst_pe_last", int'(pe_last_a), 0);
        rst = 1'b0;
        mon_en = 1;
        tick();

        // Table of ungated jobs
        for (int v = 0; v < 4; v++) begin
            start_job(vecs[v].n, vecs[v].n == 2);
            wait_job();
            chk("tbl_beats", beats_a, vecs[v].beats);
            chk("tbl_buf_a", buf_cnt_a, vecs[v].buf_a);
            chk("tbl_fifo_a", fifo_cnt_a, vecs[v].fifo_a);
            chk("tbl_buf_b", buf_cnt_b, vecs[v].buf_b);
            chk("tbl_fifo_b", fifo_cnt_b, vecs[v].fifo_b);
            chk("tbl_latency", done_cyc_a - t0, vecs[v].lat);
            chk("tbl_ne_stalls", ne_a, 0);
            chk("tbl_beat_gap", gap_a, 0);
            tick();
        end

        // buf_rdy low for 3 cycles right when the row-1 IB load (command 16) is decided
        start_job(2, 0);
        guard = 0;
        while (cmds_a < 15 && guard < 100) begin tick(); guard++; end
        chk("bufstall_reached", int'(cmds_a == 15), 1);
        buf_rdy = 1'b0;
        tick(); tick(); tick();
        buf_rdy = 1'b1;
        wait_job();
        chk("bufstall_ne", ne_a, 3);
        chk("bufstall_gap", gap_a, 3);
        chk("bufstall_beats", beats_a, 18);
        chk("bufstall_buf_rd", buf_cnt_a, 4);
        chk("bufstall_fifo_rd", fifo_cnt_a, 2);
        tick();

        // pe_ready low for 2 cycles in the middle of a kernel row
        start_job(1, 0);
        guard = 0;
        while (cmds_a < 4 && guard < 100) begin tick(); guard++; end
        pe_ready = 1'b0;
        tick(); tick();
        pe_ready = 1'b1;
        wait_job();
        chk("pestall_ne", ne_a, 2);
        chk("pestall_gap", gap_a, 2);
        chk("pestall_beats", beats_a, 9);
        chk("pestall_latency", done_cyc_a - t0, 12);
        tick();

        // Reset in the middle of a job aborts without done
        start_job(2, 0);
        guard = 0;
        while (beats_a < 5 && guard < 100) begin tick(); guard++; end
        chk("rst_mid_reached", beats_a, 5);
        mon_en = 0;
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", int'(busy_a), 0);
        chk("rst_mid_cmd", int'(cmd_a), int'(CMD_NE));
        chk("rst_mid_pe_valid", int'(pe_valid_a), 0);
        chk("rst_mid_busy_b", int'(busy_b), 0);
        rst = 1'b0;
        exp_cmd_a.delete(); exp_cmd_b.delete(); exp_beat_a.delete();
        done_seen_a = 0;
        mon_en = 1;
        for (int i = 0; i < 12; i++) tick();
        chk("rst_mid_no_done", int'(done_seen_a), 0);
        start_job(1, 0);
        wait_job();
        chk("after_rst_beats", beats_a, 9);
        tick();

        // start while busy is ignored
        start_job(1, 0);
        tick(); tick(); tick();
        start = 1'b1; n_rows = 8'd3;
        tick();
        start = 1'b0;
        wait_job();
        chk("busy_start_beats", beats_a, 9);
        chk("busy_start_latency", done_cyc_a - t0, 10);
        for (int i = 0; i < 5; i++) tick();
        chk("busy_start_idle", int'(busy_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_array_ctrl.md
# reg_array_ctrl

Sequencer for one `reg_array` instance in the data router. It issues the 2-bit `reg_array_cmd` stream for each output row: a buffer or FIFO load at the start of every kernel row, followed by KSIZE-1 shifts. It throttles that stream against buffer/FIFO readiness and PE back-pressure, and tags every window beat delivered to the PEs with its kernel coordinates. It sits between the layer controller (start/done) and the `reg_array`, line buffer and FIFO.

## Interface
- `KSIZE`, 3, kernel width/height; also the number of commands per kernel row.
- `STRIDE`, 1, vertical stride; selects which kernel rows are FIFO-reused.
- `ROWW`, 8, width of the output-row counter.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `n_rows`  in  ROWW  output rows to process; sampled on accepted `start`.
- `busy`  out  1  high from the cycle after accept through the `done` cycle.
- `done`  out  1  one-cycle pulse, coincident with the final `pe_valid`.
- `buf_rdy`  in  1  line buffer has the next row available.
- `buf_rd`  out  1  pulse in the cycle an IB command is presented.
- `fifo_rdy`  in  1  reuse FIFO has the next row available.
- `fifo_rd`  out  1  pulse in the cycle an IF command is presented.
- `pe_ready`  in  1  PE throttle; low blocks the next command.
- `reg_array_cmd`  out  2  IB=00, SF=01, IF=10, NE=11; registered.
- `pe_valid`  out  1  `reg_array` outputs hold a valid window column this cycle.
- `pe_kx`, `pe_ky`  out  $clog2(KSIZE) each  kernel column/row of the current beat.
- `pe_last`  out  1  final beat of the current output row.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `reg_array_cmd`=NE. On `start` with `n_rows`≠0, go to LOAD; clear `row`, `ky` and `kx`. On `start` with `n_rows`=0, go to DONE with no commands issued.
- LOAD: the source is IF when `row`>0 and `ky` < KSIZE-STRIDE; otherwise it is IB.
  - Issue the load only when `pe_ready`=1 and the selected source ready (`buf_rdy` or `fifo_rdy`) is 1. Otherwise present NE and stay in LOAD.
  - On issue, pulse `buf_rd` or `fifo_rd`, set `kx`=0, then go to SHIFT if KSIZE>1.
- SHIFT: issue SF while `pe_ready`=1, otherwise NE. Each SF increments `kx`.
  - After `kx` reaches KSIZE-1: increment `ky` and return to LOAD.
  - After `ky` wraps: increment `row`.
  - After `row` reaches `n_rows`-1 with the final beat issued: go to DONE.
- DONE: present NE, pulse `done` aligned with the final `pe_valid`, return to IDLE.
- Every non-NE command produces exactly one `pe_valid` beat. Each output row is KSIZE×KSIZE beats in order ky-major, kx-minor.
- `start` while busy is ignored. Asserting `rst` mid-row aborts immediately: IDLE, counters zeroed, no `done`.
- No command other than IB, SF or IF is ever issued while busy, except NE stalls.

## Timing
- Reset values: `reg_array_cmd`=NE, `busy`=0, `done`=0, `buf_rd`=0, `fifo_rd`=0, `pe_valid`=0, `pe_kx`=0, `pe_ky`=0, `pe_last`=0.
- `start` accepted at edge t: first command visible at t+1 at the earliest. `reg_array` captures it at t+2, so the first `pe_valid` is at t+2.
- `pe_valid`, `pe_kx`, `pe_ky` and `pe_last` are the command-cycle values delayed one cycle (registered pipeline stage).
- `buf_rd` and `fifo_rd` are coincident with the IB/IF command cycle.
- `pe_ready` sampled low at edge e forces NE in the cycle after e. The PE must absorb one in-flight beat (one-beat skid).
- Ungated throughput: one beat per cycle, KSIZE² cycles per row, no bubbles between rows.

## Structure
- `data_router_pkg`: cmd localparams (IB, SF, IF, NE) and the `ctrl_state_t` enum. Shared with `reg_array` and sibling controllers.
- One natural sub-module, `win_counter`: nested kx/ky/row counters with wrap flags, parameterised by KSIZE and ROWW.

## Test plan
- KSIZE=3, STRIDE=1, `n_rows`=2, all ready high:
  - commands IB,SF,SF ×3;
  - then IF,SF,SF,IF,SF,SF,IB,SF,SF;
  - 18 `pe_valid`; `done` and `pe_last` on beat 18; `buf_rd`×4, `fifo_rd`×2.
- STRIDE=2, `n_rows`=2: row 1 kernel row 0 uses IF, kernel rows 1 and 2 use IB.
- `buf_rdy` low 3 cycles at a row-1 IB load: 3 NE cycles, no `buf_rd`; sequence resumes unchanged and the beat count is still 18.
- `pe_ready` low 2 cycles mid-SHIFT: exactly 2 NE commands; `pe_valid` gap of 2 delayed one cycle; `kx` is not skipped.
- `rst` pulsed at beat 5: next cycle `busy`=0 and cmd=NE, no `done`. A new `start` with `n_rows`=1 produces 9 beats.
- `start` with `n_rows`=0: `done` after one cycle, no commands. `start` while busy: ignored.
